// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq : sequential 32-bit signed integer divider (DIV slot of the ALU).
//
// Radix-2 non-restoring division on operand magnitudes, one quotient bit per
// clock. Result layout matches the multiplier's HI/LO packing:
//     C = {remainder[31:0], quotient[31:0]}
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Divide-by-zero short-circuits straight to DONE with C = {A, 32'hFFFF_FFFF}.
//
// Ports
//   clock  in   1   rising-edge clock
//   clear  in   1   asynchronous active-high reset
//   start  in   1   request, sampled only while idle (or on the DONE exit edge)
//   A      in  32   dividend, signed two's complement
//   B      in  32   divisor, signed two's complement
//   busy   out  1   high while a division is in progress (CALC/FIX)
//   done   out  1   one-cycle pulse, C valid and updated
//   dbz    out  1   divide-by-zero flag of the last result
//   C      out 64   {remainder, quotient}
// -----------------------------------------------------------------------------
module div_seq (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic        dbz,
    output logic [63:0] C
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Two's-complement magnitude; -2^31 maps to 32'h8000_0000 (unsigned).
    function automatic logic [31:0] mag32(input logic [31:0] v);
        logic [31:0] m;
        if (v[31]) begin
            m = ~v + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [32:0] r_q,     r_d;       // signed partial remainder
    logic [31:0] q_q,     q_d;       // dividend magnitude shifting into quotient
    logic [31:0] bmag_q,  bmag_d;
    logic        asign_q, asign_d;
    logic        qsign_q, qsign_d;
    logic [63:0] c_q,     c_d;
    logic        dbz_q,   dbz_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;

    logic [32:0] r_sh_s;
    logic [32:0] r_step_s;
    logic [32:0] r_fix_s;
    logic [31:0] q_out_s;
    logic [31:0] r_out_s;

    // Next-state and datapath logic for the divider FSM.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        r_d      = r_q;
        q_d      = q_q;
        bmag_d   = bmag_q;
        asign_d  = asign_q;
        qsign_d  = qsign_q;
        c_d      = c_q;
        dbz_d    = dbz_q;
        r_sh_s   = {r_q[31:0], q_q[31]};
        r_step_s = 33'd0;
        r_fix_s  = 33'd0;
        q_out_s  = 32'd0;
        r_out_s  = 32'd0;

        case (state_q)
            // DONE accepts a new request on its exit edge, giving 34-cycle throughput.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (B != 32'd0) begin
                        r_d     = 33'd0;
                        q_d     = mag32(A);
                        bmag_d  = mag32(B);
                        asign_d = A[31];
                        qsign_d = A[31] ^ B[31];
                        count_d = 6'd0;
                        dbz_d   = 1'b0;
                        state_d = ST_CALC;
                    end else begin
                        c_d     = {A, 32'hFFFF_FFFF};
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                // Subtract while the remainder is non-negative, add it back otherwise.
                if (!r_q[32]) begin
                    r_step_s = r_sh_s - {1'b0, bmag_q};
                end else begin
                    r_step_s = r_sh_s + {1'b0, bmag_q};
                end
                r_d     = r_step_s;
                q_d     = {q_q[30:0], ~r_step_s[32]};
                count_d = count_q + 6'd1;
                if (count_q == 6'd31) begin
                    state_d = ST_FIX;
                end else begin
                    state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                if (r_q[32]) begin
                    r_fix_s = r_q + {1'b0, bmag_q};
                end else begin
                    r_fix_s = r_q;
                end
                if (qsign_q) begin
                    q_out_s = ~q_q + 32'd1;
                end else begin
                    q_out_s = q_q;
                end
                if (asign_q) begin
                    r_out_s = ~r_fix_s[31:0] + 32'd1;
                end else begin
                    r_out_s = r_fix_s[31:0];
                end
                r_d     = r_fix_s;
                c_d     = {r_out_s, q_out_s};
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_FIX);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; clear aborts any operation in flight.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            count_q <= 6'd0;
            r_q     <= 33'd0;
            q_q     <= 32'd0;
            bmag_q  <= 32'd0;
            asign_q <= 1'b0;
            qsign_q <= 1'b0;
            c_q     <= 64'd0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_q     <= r_d;
            q_q     <= q_d;
            bmag_q  <= bmag_d;
            asign_q <= asign_d;
            qsign_q <= qsign_d;
            c_q     <= c_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;
    assign C    = c_q;

endmodule

// File: tb/tb_div_seq.sv
// -----------------------------------------------------------------------------
// tb_div_seq : self-checking bench for div_seq. Expected results come from
// plain signed 64-bit arithmetic (truncating division, dividend-signed
// remainder) plus the divide-by-zero rule.
// -----------------------------------------------------------------------------
module tb_div_seq;

    logic        clock;
    logic        clear;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [63:0] C;

    int n_cmp;
    int n_err;

    div_seq dut (
        .clock (clock),
        .clear (clear),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .C     (C)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports mismatches.
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: high-level arithmetic definition of the packed result.
    function automatic logic [63:0] ref_c(input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // One division: launch, measure latency/busy, check result. If scramble is
    // set, inputs and start are randomly toggled during edges 5..20.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                          input string tag);
        int edges;
        int busy_cnt;
        int done_cnt;
        int exp_lat;
        @(negedge clock);
        A = a; B = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        edges = 0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        exp_lat = (b == 32'd0) ? 0 : 33;
        while (!done && edges < 100) begin
            @(posedge clock); #1;
            edges++;
            if (busy) busy_cnt++;
            check_val({tag, "_busy_done_excl"}, {63'd0, busy & done}, 64'd0);
            if (scramble) begin
                if (edges >= 5 && edges <= 20) begin
                    A = $urandom; B = $urandom; start = 1'($urandom_range(1, 0));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        if (done) done_cnt = 1;
        check_val({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check_val({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
        check_val({tag, "_C"}, C, ref_c(a, b));
        check_val({tag, "_dbz"}, {63'd0, dbz}, {63'd0, b == 32'd0});
        @(posedge clock); #1;
        check_val({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
        check_val({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check_val({tag, "_C_hold"}, C, ref_c(a, b));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear = 1'b1; start = 1'b0; A = 32'd0; B = 32'd0;
        #1;
        check_val("reset_C", C, 64'd0);
        check_val("reset_flags", {61'd0, busy, done, dbz}, 64'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        clear = 1'b0;

        do_div(32'd100, 32'd7, 1'b0, "p100_7");
        check_val("p100_7_literal", C, 64'h0000_0002_0000_000E);
        do_div(32'hFFFF_FF9C, 32'd7, 1'b0, "m100_7");
        check_val("m100_7_literal", C, 64'hFFFF_FFFE_FFFF_FFF2);
        do_div(32'd100, 32'hFFFF_FFF9, 1'b0, "p100_m7");
        check_val("p100_m7_literal", C, 64'h0000_0002_FFFF_FFF2);
        do_div(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b0, "m100_m7");
        check_val("m100_m7_literal", C, 64'hFFFF_FFFE_0000_000E);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "min_m1");
        check_val("min_m1_literal", C, 64'h0000_0000_8000_0000);
        do_div(32'h8000_0000, 32'h8000_0000, 1'b0, "min_min");
        check_val("min_min_literal", C, 64'h0000_0000_0000_0001);
        do_div(32'd1234, 32'd0, 1'b0, "dbz");
        check_val("dbz_literal", C, 64'h0000_04D2_FFFF_FFFF);
        do_div(32'd9, 32'd3, 1'b0, "after_dbz");
        check_val("after_dbz_literal", C, 64'h0000_0000_0000_0003);
        do_div(32'd100, 32'd7, 1'b1, "scramble");
        check_val("scramble_literal", C, 64'h0000_0002_0000_000E);

        // Abort mid-operation with clear between E10 and E11.
        @(negedge clock);
        A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        clear = 1'b1;
        #1;
        check_val("abort_C", C, 64'd0);
        check_val("abort_flags", {61'd0, busy, done, dbz}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check_val("abort_no_done", {63'd0, done}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        do_div(32'd50, 32'd5, 1'b0, "after_abort");
        check_val("after_abort_literal", C, 64'h0000_0000_0000_000A);

        // Randomized operands with a bias toward boundary values.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(5, 0))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'(32'($urandom_range(15, 0)) - 32'd8);
                3: rb = ra;
                default: ;
            endcase
            do_div(ra, rb, 1'b0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_seq.md
# div_seq

Sequential 32-bit signed integer divider: the inverse of the datapath's combinational Booth multiplier, occupying the same ALU slot for the DIV instruction. It takes a dividend and a divisor and produces quotient and remainder packed into one 64-bit result, in the same layout the multiplier uses for HI/LO. It uses radix-2 non-restoring division on operand magnitudes, one quotient bit per clock, with a start/done handshake to the control unit.

## Interface
- No parameters; width fixed at 32/64.
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only while idle
- A  in  32  dividend, signed two's complement
- B  in  32  divisor, signed two's complement
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse; C valid and updated
- dbz  out  1  divide-by-zero flag for the last result; held until the next accepted start
- C  out  64  {remainder[31:0], quotient[31:0]} (HI = remainder, LO = quotient)

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, start=1, B!=0: capture |A|, |B|, sign(A), sign(A)^sign(B). Clear the 33-bit partial remainder. Set count=0. Clear dbz. Go to CALC.
- IDLE, start=1, B==0: load C={A, 32'hFFFF_FFFF}, set dbz=1, go to DONE. No iteration.
- CALC: each edge performs one non-restoring step:
  - Shift {R,Q} left by 1.
  - If R is non-negative, R=R-|B|; otherwise R=R+|B|.
  - The new quotient LSB is the inverse of R's sign bit.
  - Increment count. After the 32nd step, go to FIX.
- FIX:
  - If R is negative, R=R+|B|.
  - Negate Q if the quotient sign is 1.
  - Negate R if sign(A) is 1.
  - Load C. Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- Arithmetic rules:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - Invariant: A = Q*B + R, with |R| < |B|.
  - Magnitude of -2^31 is 0x8000_0000, treated as unsigned 32-bit.
  - -2^31 / -1 gives Q=0x8000_0000, R=0 (wraps; no overflow flag).
- start while not IDLE: ignored. It is not queued.
- A and B are sampled only on the accepting edge. Later changes have no effect on the result in flight.
- C and dbz hold their values between operations. C changes only on the edge entering DONE.

## Timing
- Reset (clear=1, any time, asynchronous): state=IDLE, count=0, busy=0, done=0, dbz=0, C=64'h0.
  - Clear during an operation aborts it. No done is issued.
  - start is accepted on the first clock edge after clear deasserts.
- Latency for normal division:
  - Accepting edge = E0; steps occur on E1..E32.
  - FIX executes on E33, and C is loaded on E33.
  - done is high from E33 to E34.
  - busy is high from E0 to E33, i.e. 33 cycles, and low during DONE.
- Latency for divide-by-zero: C and dbz are updated on E0. done is high from E0 to E1. busy stays 0.
- Back-to-back: a new start can be accepted on the edge that leaves DONE (E34 normally). Throughput is one division per 34 cycles.
- done and busy are never high at the same time.
- count is 6 bits and does not wrap within an operation.

## Test plan
- A=100, B=7, start pulse → done exactly 33 edges after acceptance; C=64'h0000_0002_0000_000E; dbz=0; busy high for 33 cycles.
- A=-100 (0xFFFF_FF9C), B=7 → C=64'hFFFF_FFFE_FFFF_FFF2. Then A=100, B=-7 → C=64'h0000_0002_FFFF_FFF2. Then A=-100, B=-7 → C=64'hFFFF_FFFE_0000_000E.
- A=0x8000_0000, B=0xFFFF_FFFF → C=64'h0000_0000_8000_0000. Also A=0x8000_0000, B=0x8000_0000 → C=64'h0000_0000_0000_0001.
- A=1234, B=0 → next edge: dbz=1, done=1, C=64'h0000_04D2_FFFF_FFFF, busy never asserted. A following 9/3 clears dbz and gives C=64'h0000_0000_0000_0003.
- Start 100/7; toggle A, B, and start during E5..E20 → result unchanged from the first test, with only one done pulse.
- Start 100/7; assert clear mid-cycle between E10 and E11 → outputs go to zero immediately with no done pulse. After release, start 50/5 → C=64'h0000_0000_0000_000A after 33 edges.
